// File: rtl/apb2reg_bridge.sv
// apb2reg_bridge: converts APB slave transfers into one-cycle read/write
// strobes for a simple register block inside a byte-addressed window.
//
// Ports
//   i_clk, i_rst_n    clock (rising edge) and asynchronous active-low reset
//   i_psel, i_penable APB select and access-phase enable
//   i_pwrite          APB direction, 1 = write
//   i_paddr           APB byte address
//   i_pwdata          APB write data
//   o_pready          transfer complete (one cycle, in RESP)
//   o_prdata          read data, non-zero only in RESP of an error-free read
//   o_pslverr         error response, only meaningful with o_pready
//   o_reg_write       one-cycle write strobe to the register block
//   o_reg_read        one-cycle read strobe to the register block
//   o_reg_addr        register offset (i_paddr - BASE_ADDR), held until next setup
//   o_reg_wdata       register write data, held until next setup
//   i_reg_rdata       register read data, valid the cycle after o_reg_read
//   o_err_cnt         saturating count of error responses
module apb2reg_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_0004
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [31:0] i_paddr,
  input  logic [31:0] i_pwdata,
  output logic        o_pready,
  output logic [31:0] o_prdata,
  output logic        o_pslverr,
  output logic        o_reg_write,
  output logic        o_reg_read,
  output logic [31:0] o_reg_addr,
  output logic [31:0] o_reg_wdata,
  input  logic [31:0] i_reg_rdata,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e          state_q;
  logic            pwrite_q;
  logic            err_q;
  logic [AW-1:0]   reg_addr_q;
  logic [DW-1:0]   reg_wdata_q;
  logic [DW-1:0]   prdata_q;
  logic            pready_q;
  logic            pslverr_q;
  logic            reg_write_q;
  logic            reg_read_q;
  logic [CW-1:0]   err_cnt_q;

  // Setup-phase decode of the incoming address
  logic            setup_c;
  logic [AW-1:0]   offset_c;
  logic            addr_err_c;

  assign setup_c    = i_psel & ~i_penable;
  // Unsigned 32-bit wrap: addresses below the base produce a huge offset,
  // but they are also flagged explicitly so the window check never relies on it.
  assign offset_c   = i_paddr - BASE_ADDR;
  assign addr_err_c = (i_paddr[1:0] != 2'b00) |
                      (i_paddr < BASE_ADDR)   |
                      (offset_c >= ADDR_SPAN);

  // Transfer FSM with all outputs registered; strobes, pready and prdata are
  // single-cycle pulses, so they default to 0 every cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pwrite_q    <= 1'b0;
      err_q       <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;

      case (state_q)
        S_IDLE: begin
          // A lone penable without a setup phase is ignored here.
          if (setup_c) begin
            state_q     <= S_ACCESS;
            pwrite_q    <= i_pwrite;
            err_q       <= addr_err_c;
            reg_addr_q  <= offset_c;
            reg_wdata_q <= i_pwdata;
            // Strobe is launched now so it is visible for the ACCESS cycle.
            reg_write_q <= i_pwrite & ~addr_err_c;
            reg_read_q  <= ~i_pwrite & ~addr_err_c;
          end
        end

        S_ACCESS: begin
          if (!err_q && !pwrite_q) begin
            state_q <= S_RD_WAIT;
          end else begin
            state_q   <= S_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
          end
        end

        S_RD_WAIT: begin
          // Register block answers one cycle after the read strobe.
          state_q  <= S_RESP;
          pready_q <= 1'b1;
          prdata_q <= i_reg_rdata;
        end

        S_RESP: begin
          state_q <= S_IDLE;
          if (pslverr_q && (err_cnt_q != {CW{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pready    = pready_q;
  assign o_prdata    = prdata_q;
  assign o_pslverr   = pslverr_q;
  assign o_reg_write = reg_write_q;
  assign o_reg_read  = reg_read_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_err_cnt   = err_cnt_q;

  // Structural invariants of the strobe and response pulses
  a_strobe_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(reg_write_q && reg_read_q));
  a_pready_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    pready_q |=> !pready_q);
  a_strobe_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (reg_write_q || reg_read_q) |=> !(reg_write_q || reg_read_q));

endmodule

// File: doc/apb2reg_bridge.md
APB2REG_BRIDGE -- requirements
Module: apb2reg_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte base address of the register window.
REQ-002 Parameter ADDR_SPAN, default 32'h0000_0004: window size in bytes; a non-zero multiple of 4.
REQ-003 i_clk  input  1  single clock for all logic; all flops on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_psel  input  1  APB select.
REQ-006 i_penable  input  1  APB enable (access phase).
REQ-007 i_pwrite  input  1  APB direction; 1 = write.
REQ-008 i_paddr  input  32  APB byte address.
REQ-009 i_pwdata  input  32  APB write data.
REQ-010 o_pready  output  1  APB transfer-complete.
REQ-011 o_prdata  output  32  APB read data.
REQ-012 o_pslverr  output  1  APB error response, valid only with o_pready.
REQ-013 o_reg_write  output  1  one-cycle write strobe to the register block.
REQ-014 o_reg_read  output  1  one-cycle read strobe to the register block.
REQ-015 o_reg_addr  output  32  register offset, i_paddr - BASE_ADDR.
REQ-016 o_reg_wdata  output  32  register write data.
REQ-017 i_reg_rdata  input  32  register read data, valid the cycle after o_reg_read.
REQ-018 o_err_cnt  output  8  saturating count of error responses.

Function
REQ-019 FSM states: IDLE, ACCESS, RD_WAIT, RESP; state is a flop.
REQ-020 IDLE: on i_psel=1 & i_penable=0 (setup), latch paddr, pwdata, pwrite and error flag, then go to ACCESS; otherwise stay in IDLE.
REQ-021 Error flag is set when i_paddr[1:0] != 0, when i_paddr < BASE_ADDR, or when i_paddr - BASE_ADDR >= ADDR_SPAN; the subtraction uses 32-bit unsigned arithmetic.
REQ-022 ACCESS (one cycle): if the error flag is 0, assert o_reg_write (write) or o_reg_read (read) for exactly this cycle; if the error flag is 1, assert no strobe.
REQ-023 ACCESS next state: RD_WAIT for a read without error; RESP otherwise.
REQ-024 RD_WAIT (one cycle): capture i_reg_rdata into the read-data register, then go to RESP.
REQ-025 RESP (one cycle): o_pready=1 and o_pslverr=error flag, then go to IDLE unconditionally.
REQ-026 Latency from the setup-sample cycle T0: write or error completes with o_pready at T2; read completes at T3.
REQ-027 o_prdata equals the captured data during RESP of an error-free read; it is 0 in every other cycle.
REQ-028 o_reg_addr and o_reg_wdata hold the latched values from ACCESS until the next setup is latched; they are 0 after reset.
REQ-029 o_reg_write and o_reg_read are never asserted together, and never outside ACCESS.
REQ-030 o_err_cnt increments by 1 in each RESP cycle with o_pslverr=1 and saturates at 8'hFF without wrapping.
REQ-031 i_psel or i_penable deasserted in ACCESS, RD_WAIT or RESP (protocol violation): the FSM completes its sequence unchanged and returns to IDLE; no extra strobe is issued.
REQ-032 i_penable=1 in IDLE without a preceding setup is ignored.
REQ-033 Back-to-back transfers: a setup presented in the cycle after RESP is accepted from IDLE; each transfer issues exactly one strobe.

Reset
REQ-034 While i_rst_n=0, asynchronously: state=IDLE, all outputs 0 (o_pready, o_pslverr, o_prdata, o_reg_*, o_err_cnt), latched fields 0.
REQ-035 Reset asserted mid-transfer aborts the transfer: no o_pready, and strobes drop immediately.
REQ-036 After reset release, the first setup is accepted on the first rising edge at which it is sampled.

Verification
REQ-037 Write 0xA5A5_0001 to 0x0000_0000 with defaults -> o_reg_write high one cycle at T1 with o_reg_addr=0 and o_reg_wdata=0xA5A5_0001; o_pready=1 and o_pslverr=0 at T2.
REQ-038 Read 0x0000_0000 with i_reg_rdata=0x0000_0001 at T2 -> o_reg_read high at T1 only; at T3 o_pready=1 and o_prdata=0x0000_0001; o_prdata=0 at T4.
REQ-039 Access 0x0000_0004 and 0x0000_0002 -> no strobes; o_pready=1 and o_pslverr=1 at T2; o_err_cnt goes 0->1->2.
REQ-040 BASE_ADDR=0x4000_0000, access 0x3FFF_FFFC -> error; access 0x4000_0000 -> o_reg_addr=0, no error.
REQ-041 Reset pulse during RD_WAIT -> all outputs 0 immediately, no o_pready; the next read after release completes normally at T3.
REQ-042 260 consecutive error accesses -> o_err_cnt stays at 8'hFF; back-to-back write then read each produce exactly one strobe.
